// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction-fetch sequencer. Holds the PC, applies branches,
//            halts on Ack and counts retired instructions.
//            Optional relative branches: define FETCH_REL_BRANCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [5:0]       PCTarg,
    input  logic             BranchRel,
    input  logic             Ack,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  c_START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]  c_PC_ONE   = PC_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state_q, w_state_d;
    logic [PC_W-1:0]  r_pc_q,    w_pc_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;

    logic [PC_W-1:0]  w_branch_pc;
    logic [CNT_W-1:0] w_cnt_inc;

`ifdef FETCH_REL_BRANCH_EN
    logic [PC_W-1:0] w_rel_off;
    assign w_rel_off   = {{(PC_W-6){PCTarg[5]}}, PCTarg};
    assign w_branch_pc = BranchRel ? (r_pc_q + w_rel_off)
                                   : {r_pc_q[PC_W-1:6], PCTarg};
`else
    logic w_unused_branch_rel;
    assign w_unused_branch_rel = BranchRel;
    assign w_branch_pc         = {r_pc_q[PC_W-1:6], PCTarg};
`endif

    // Counter saturates rather than wrapping so long runs stay meaningful
    assign w_cnt_inc = (r_cnt_q == c_CNT_MAX) ? r_cnt_q : (r_cnt_q + c_CNT_ONE);

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    w_state_d = ST_RUN;
                    w_pc_d    = c_START_PC;
                    w_cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    w_cnt_d = w_cnt_inc;
                    if (Ack) begin
                        w_state_d = ST_HALT;
                    end else if (Branch) begin
                        w_pc_d = w_branch_pc;
                    end else begin
                        w_pc_d = r_pc_q + c_PC_ONE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q <= ST_IDLE;
            r_pc_q    <= c_START_PC;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign ProgCtr    = r_pc_q;
    assign Running    = (r_state_q == ST_RUN);
    assign Done       = (r_state_q == ST_HALT);
    assign InstrCount = r_cnt_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch/sequencing unit: the consumer end of the control decoder's Branch/PCTarg/Ack outputs.
- Holds the program counter and drives ProgCtr to the combinational instruction ROM.
- Applies absolute branches, halts on the Ack instruction, and runs a Start/Done handshake with the testbench/top level.
- Counts retired instructions for performance reporting.

Parameters:
- PC_W, 10, program counter width in bits; must be >= 6.
- START_ADDR, 0, PC value loaded on reset and on every Start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin program; sampled in IDLE and HALT only.
- Stall  input  1  freeze fetch this cycle; no retire.
- Branch  input  1  from control decoder; take branch this cycle.
- PCTarg  input  6  from control decoder; branch target (low PC bits).
- BranchRel  input  1  relative-branch select; used only with FETCH_REL_BRANCH_EN.
- Ack  input  1  from control decoder; current instruction is the halt instruction.
- ProgCtr  output  PC_W  address into the instruction ROM.
- Running  output  1  high while in RUN.
- Done  output  1  high while in HALT.
- InstrCount  output  CNT_W  number of instructions retired since the last Start.

Behaviour:
- Reset is synchronous, active-high, one clock, and wins over all other inputs in every state. On reset: state=IDLE, ProgCtr=START_ADDR, Running=0, Done=0, InstrCount=0. Reset mid-RUN aborts the program immediately.
- States: IDLE, RUN, HALT. All outputs are registered or decoded directly from state. Running=(state==RUN). Done=(state==HALT).
- IDLE:
  - Start=1 -> RUN next cycle, with ProgCtr=START_ADDR and InstrCount=0.
  - Branch, Ack and Stall are ignored.
- RUN: one instruction retires per cycle when Stall=0. Priority per cycle:
  - Stall=1: hold ProgCtr, InstrCount and state. Branch and Ack are ignored.
  - Ack=1: go to HALT. ProgCtr holds (it still points at the Ack instruction). InstrCount+1. Branch is ignored.
  - Branch=1: ProgCtr <= {ProgCtr[PC_W-1:6], PCTarg}, an absolute target within the current 64-word page. InstrCount+1.
  - Otherwise: ProgCtr <= ProgCtr+1, wrapping mod 2^PC_W (all-ones -> 0). InstrCount+1.
  - Start is ignored in RUN.
- HALT:
  - Done=1 and ProgCtr are held.
  - Start=1 -> RUN next cycle, with ProgCtr=START_ADDR, InstrCount=0, Done low that same next cycle.
  - InstrCount is held for readout until the next Start.
- InstrCount saturates at 2^CNT_W-1 and never wraps.
- Latency: a Branch/Ack sampled at edge N is reflected in ProgCtr/Done after edge N. There is no delay slot.
- The ROM is combinational, so the instruction at ProgCtr is valid in the same cycle.

Optional Feature:
- Macro FETCH_REL_BRANCH_EN.
- Defined: when Branch=1 and BranchRel=1 (and RUN, Stall=0, Ack=0), ProgCtr <= ProgCtr + signext(PCTarg), mod 2^PC_W, with range -32..+31. BranchRel=0 keeps the absolute behaviour.
- Not defined: the BranchRel port still exists but is ignored; every branch is absolute.

Test Plan:
- Reset with START_ADDR=0, then Start pulse -> next cycle Running=1, ProgCtr=0. Five cycles with no Branch -> ProgCtr=5, InstrCount=5.
- At ProgCtr=0x047, Branch=1, PCTarg=6'h12 -> next ProgCtr=0x052. InstrCount increments by 1.
- Stall=1 held 3 cycles with Branch=1, Ack=1 -> ProgCtr, InstrCount and state unchanged. Release Stall -> normal retire resumes.
- At ProgCtr=9, Ack=1 together with Branch=1 -> HALT: Done=1, Running=0, ProgCtr=9, InstrCount=10. Start in HALT -> RUN, ProgCtr=0, InstrCount=0.
- Force ProgCtr to 0x3FF (PC_W=10) with no branch -> wraps to 0x000. Reset asserted mid-RUN -> next cycle IDLE, ProgCtr=START_ADDR, InstrCount=0.
- With FETCH_REL_BRANCH_EN: at ProgCtr=0x100, Branch=1, BranchRel=1, PCTarg=6'h3E (-2) -> ProgCtr=0x0FE. Without the macro, the same stimulus -> ProgCtr=0x13E.
